// File: rtl/ioctrl.sv
// Memory-mapped I/O controller: routes arbiter accesses to a synchronous SRAM, an LED register
// and a free-running cycle counter; anything else completes with a bus error.
module ioctrl #(
  parameter int unsigned RAM_AW   = 14,
  parameter int unsigned RAM_WAIT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_data_write,
  output logic              mem_ack,
  output logic [31:0]       mem_data_read,
  output logic              ram_en,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic [7:0]        led,
  output logic              bus_error
);

  localparam logic [31:0] AddrMask = 32'hFFFF_FFFC;
  localparam logic [31:0] LedAddr  = 32'h8000_0000;
  localparam logic [31:0] CntAddr  = 32'h8000_0004;

  typedef enum logic [1:0] {StIdle, StRamCmd, StRamWait, StReg} state_e;

  state_e      state_q;
  logic [31:0] addr_q;
  logic [7:0]  led_wdata_q;
  logic        write_q;
  logic [3:0]  wait_q;
  logic [31:0] cycle_q;
  logic        is_ram;

  assign is_ram = (mem_addr >> (RAM_AW + 2)) == 32'd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      addr_q        <= 32'd0;
      led_wdata_q   <= 8'd0;
      write_q       <= 1'b0;
      wait_q        <= 4'd0;
      cycle_q       <= 32'd0;
      mem_ack       <= 1'b0;
      mem_data_read <= 32'd0;
      ram_en        <= 1'b0;
      ram_we        <= 1'b0;
      ram_addr      <= '0;
      ram_wdata     <= 32'd0;
      led           <= 8'd0;
      bus_error     <= 1'b0;
    end else begin
      cycle_q   <= cycle_q + 32'd1;
      mem_ack   <= 1'b0;
      bus_error <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (mem_read || mem_write) begin
            addr_q      <= mem_addr;
            led_wdata_q <= mem_data_write[7:0];
            // A simultaneous read and write strobe is a write.
            write_q     <= mem_write;
            if (is_ram) begin
              // SRAM command is registered here so ram_en is high for the whole RAM_CMD cycle.
              ram_en    <= 1'b1;
              ram_we    <= mem_write;
              ram_addr  <= mem_addr[RAM_AW+1:2];
              ram_wdata <= mem_data_write;
              state_q   <= StRamCmd;
            end else begin
              state_q <= StReg;
            end
          end
        end
        StRamCmd: begin
          ram_en  <= 1'b0;
          ram_we  <= 1'b0;
          wait_q  <= 4'(RAM_WAIT - 1);
          state_q <= StRamWait;
        end
        StRamWait: begin
          if (wait_q == 4'd0) begin
            if (!write_q) mem_data_read <= ram_rdata;
            mem_ack <= 1'b1;
            state_q <= StIdle;
          end else begin
            wait_q <= wait_q - 4'd1;
          end
        end
        StReg: begin
          mem_ack <= 1'b1;
          state_q <= StIdle;
          if ((addr_q & AddrMask) == LedAddr) begin
            if (write_q) led <= led_wdata_q;
            mem_data_read <= write_q ? 32'd0 : {24'd0, led};
          end else if ((addr_q & AddrMask) == CntAddr) begin
            mem_data_read <= write_q ? 32'd0 : cycle_q;
          end else begin
            bus_error     <= 1'b1;
            mem_data_read <= 32'd0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ioctrl.sv
// Self-checking bench for ioctrl: directed scenarios followed by random accesses checked against
// an address-map level reference model and a latency-accurate SRAM model.
module tb_ioctrl;

  localparam int unsigned RAM_AW   = 14;
  localparam int unsigned RAM_WAIT = 2;

  logic              clk;
  logic              reset;
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_data_write;
  logic              mem_ack;
  logic [31:0]       mem_data_read;
  logic              ram_en;
  logic              ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;
  logic [7:0]        led;
  logic              bus_error;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] ref_mem [int];
  logic [31:0] sram [int];
  logic [7:0]  led_ref;
  logic [31:0] last_rd;
  int unsigned ecount;
  int          tcyc     = 0;
  int          due_cyc  = -100;
  logic [31:0] due_data = 32'd0;

  ioctrl #(
    .RAM_AW  (RAM_AW),
    .RAM_WAIT(RAM_WAIT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_addr      (mem_addr),
    .mem_data_write(mem_data_write),
    .mem_ack       (mem_ack),
    .mem_data_read (mem_data_read),
    .ram_en        (ram_en),
    .ram_we        (ram_we),
    .ram_addr      (ram_addr),
    .ram_wdata     (ram_wdata),
    .ram_rdata     (ram_rdata),
    .led           (led),
    .bus_error     (bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycles elapsed since reset release: what the counter register should read.
  always @(posedge clk or posedge reset) begin
    if (reset) ecount <= 0;
    else       ecount <= ecount + 1;
  end

  // SRAM: read data is valid only in the cycle RAM_WAIT after the enable cycle, noise otherwise.
  always @(posedge clk) begin
    tcyc = tcyc + 1;
    if (ram_en) begin
      if (ram_we) begin
        sram[int'(ram_addr)] = ram_wdata;
      end else begin
        due_cyc  = tcyc - 1 + int'(RAM_WAIT);
        due_data = sram.exists(int'(ram_addr)) ? sram[int'(ram_addr)] : 32'd0;
      end
    end
    ram_rdata <= (tcyc == due_cyc) ? due_data : $urandom();
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_mem_ack", 32'(mem_ack), 32'd0);
    check("rst_mem_data_read", mem_data_read, 32'd0);
    check("rst_ram_en", 32'(ram_en), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_wdata", ram_wdata, 32'd0);
    check("rst_led", 32'(led), 32'd0);
    check("rst_bus_error", 32'(bus_error), 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      mem_read  = 1'b0;
      mem_write = 1'b0;
      @(posedge clk);
      #1;
      check("idle_ack", 32'(mem_ack), 32'd0);
      check("hold_rdata", mem_data_read, last_rd);
    end
  endtask

  // One access; returns in the ack cycle so a following call issues back-to-back.
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit spur);
    bit          in_ram;
    bit          in_led;
    bit          in_cnt;
    bit          got_ack;
    int          word;
    int          lat;
    int          spur_i;
    int          en_cnt;
    int          err_cnt;
    logic [31:0] exp_rd;
    logic [31:0] cnt_at;
    in_ram  = (longint'(addr) >> (RAM_AW + 2)) == 0;
    in_led  = (addr & ~32'h3) == 32'h8000_0000;
    in_cnt  = (addr & ~32'h3) == 32'h8000_0004;
    word    = int'((addr >> 2) % (32'd1 << RAM_AW));
    lat     = in_ram ? 2 + int'(RAM_WAIT) : 2;
    spur_i  = in_ram ? 2 : 1;
    got_ack = 1'b0;
    en_cnt  = 0;
    err_cnt = 0;
    cnt_at  = 32'd0;
    for (int i = 0; i < 40 && !got_ack; i++) begin
      @(negedge clk);
      mem_read       = (i == 0) ? rd : (spur && i == spur_i);
      mem_write      = (i == 0) ? wr : 1'b0;
      mem_addr       = addr;
      mem_data_write = wdata;
      @(posedge clk);
      #1;
      if (i == 0) cnt_at = ecount;
      if (ram_en) begin
        en_cnt++;
        check("ram_en_cycle", 32'(i + 1), 32'd1);
        check("ram_we", 32'(ram_we), 32'(wr));
        check("ram_addr", 32'(ram_addr), 32'(word));
        check("ram_wdata", ram_wdata, wdata);
      end
      if (mem_ack) begin
        got_ack = 1'b1;
        check("ack_latency", 32'(i + 1), 32'(lat));
        if (in_ram)      exp_rd = wr ? last_rd : (ref_mem.exists(word) ? ref_mem[word] : 32'd0);
        else if (wr)     exp_rd = 32'd0;
        else if (in_led) exp_rd = {24'd0, led_ref};
        else if (in_cnt) exp_rd = cnt_at;
        else             exp_rd = 32'd0;
        if (wr && in_ram) ref_mem[word] = wdata;
        if (wr && in_led) led_ref = wdata[7:0];
        last_rd = exp_rd;
        check("rdata", mem_data_read, exp_rd);
        check("bus_error", 32'(bus_error), 32'(!(in_ram || in_led || in_cnt)));
        check("led", 32'(led), 32'(led_ref));
      end else if (bus_error) begin
        err_cnt++;
      end
    end
    if (!got_ack) check("ack_timeout", 32'd0, 32'd1);
    check("ram_en_count", 32'(en_cnt), 32'(in_ram));
    check("stray_bus_error", 32'(err_cnt), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, limit 2000000 expected earlier end");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          sel;
    int          rw;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_addr       = 32'd0;
    mem_data_write = 32'd0;
    reset          = 1'b1;
    led_ref        = 8'd0;
    last_rd        = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk);
    reset = 1'b0;
    idle(2);

    access(1'b0, 1'b1, 32'h0000_0010, 32'hCAFE_F00D, 1'b0);
    idle(1);
    access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
    access(1'b0, 1'b1, 32'h8000_0000, 32'h1234_56A5, 1'b0);
    access(1'b1, 1'b0, 32'h8000_0000, 32'h0, 1'b0);
    access(1'b1, 1'b0, 32'h4000_0000, 32'h0, 1'b0);
    idle(2);
    access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b1);
    idle(3);
    access(1'b1, 1'b1, 32'h0000_0020, 32'h55AA_55AA, 1'b0);
    access(1'b1, 1'b0, 32'h0000_0023, 32'h0, 1'b0);
    // Top RAM word, first address past RAM, write to the read-only counter, counter reads.
    access(1'b0, 1'b1, (32'd4 << RAM_AW) - 32'd4, 32'hDEAD_BEEF, 1'b0);
    access(1'b1, 1'b0, (32'd4 << RAM_AW) - 32'd1, 32'h0, 1'b0);
    access(1'b1, 1'b0, 32'd4 << RAM_AW, 32'h0, 1'b0);
    access(1'b0, 1'b1, 32'h8000_0004, 32'hFFFF_FFFF, 1'b0);
    access(1'b1, 1'b0, 32'h8000_0004, 32'h0, 1'b0);
    idle(5);
    access(1'b1, 1'b0, 32'h8000_0006, 32'h0, 1'b0);
    access(1'b1, 1'b0, 32'h0000_0020, 32'h0, 1'b0);

    // Reset in the middle of a RAM read.
    @(negedge clk);
    mem_read = 1'b1;
    mem_addr = 32'h0000_0010;
    @(negedge clk);
    mem_read = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_outputs();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("reset_ack", 32'(mem_ack), 32'd0);
    end
    @(negedge clk);
    reset   = 1'b0;
    led_ref = 8'd0;
    last_rd = 32'd0;
    idle(4);
    access(1'b1, 1'b0, 32'h8000_0004, 32'h0, 1'b0);
    access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
    access(1'b1, 1'b0, 32'h8000_0000, 32'h0, 1'b0);

    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 4) begin
        a = ($urandom_range(0, 15) == 0) ? (32'd4 << RAM_AW) - 32'd4
                                         : 32'($urandom_range(0, 31)) * 32'd4;
        a = a | 32'($urandom_range(0, 3));
      end else if (sel <= 6) begin
        a = 32'h8000_0000 | 32'($urandom_range(0, 3));
      end else if (sel == 7) begin
        a = 32'h8000_0004 | 32'($urandom_range(0, 3));
      end else begin
        do a = $urandom();
        while ((longint'(a) >> (RAM_AW + 2)) == 0 || (a & ~32'h3) == 32'h8000_0000 ||
               (a & ~32'h3) == 32'h8000_0004);
      end
      rw = $urandom_range(0, 3);
      access(rw != 2, rw >= 2, a, $urandom(), $urandom_range(0, 3) == 0);
      idle($urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
